serial_nibble_assembler: RTL

SERIAL_NIBBLE_ASSEMBLER -- requirements
Module: serial_nibble_assembler

---
 rtl/serial_nibble_assembler_pkg.sv | 18 +
 rtl/serial_nibble_assembler_if.sv | 23 ++
 rtl/serial_nibble_assembler_shift_stage.sv | 33 +++
 rtl/serial_nibble_assembler.sv | 95 +++++++++
 4 files changed

// File: rtl/serial_nibble_assembler_pkg.sv
// Shared definitions for the serial nibble assembler: FSM encoding, widths
// and the parity helper.
package serial_nibble_assembler_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_PARITY,
        ST_FULL
    } state_e;

    function automatic logic even_parity(input logic [NIBBLE_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serial_nibble_assembler_if.sv
// Serial-in / nibble-out handshake bundle; slave is the assembler side,
// master is the side driving serial bits and consuming nibbles.
interface serial_nibble_assembler_if;
    import serial_nibble_assembler_pkg::*;

    logic                SIN;
    logic                SIN_VALID;
    logic                SIN_READY;
    logic [NIBBLE_W-1:0] D_OUT;
    logic                D_VALID;
    logic                D_READY;
    logic                PARITY_ERR;

    modport slave (
        input  SIN, SIN_VALID, D_READY,
        output SIN_READY, D_OUT, D_VALID, PARITY_ERR
    );

    modport master (
        output SIN, SIN_VALID, D_READY,
        input  SIN_READY, D_OUT, D_VALID, PARITY_ERR
    );
endinterface

// File: rtl/serial_nibble_assembler_shift_stage.sv
// Working register: 4-bit shift register with enable, direction select and
// synchronous active-low clear.
module nibble_shift_stage
    import serial_nibble_assembler_pkg::*;
(
    input  logic                clk,
    input  logic                clr_n,
    input  logic                shift_en,
    input  logic                msb_first,
    input  logic                din,
    output logic [NIBBLE_W-1:0] q
);

    logic [NIBBLE_W-1:0] shift_d;
    logic [NIBBLE_W-1:0] shift_q;

    // MSB-first shifts left so the first bit ends in [3]; LSB-first shifts right so it ends in [0].
    always_comb begin
        shift_d = shift_q;
        if (shift_en) begin
            if (msb_first) shift_d = {shift_q[NIBBLE_W-2:0], din};
            else           shift_d = {din, shift_q[NIBBLE_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) shift_q <= '0;
        else        shift_q <= shift_d;
    end

    assign q = shift_q;

endmodule

// File: rtl/serial_nibble_assembler.sv
// Collects serial bits into a nibble with optional trailing even-parity bit
// and holds it under a valid/ready handshake.
module serial_nibble_assembler
    import serial_nibble_assembler_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0,
    parameter bit PARITY_EN = 1'b0
) (
    input logic                       CLK,
    input logic                       CLEAR,
    serial_nibble_assembler_if.slave  bus
);

    state_e              state_d, state_q;
    logic [CNT_W-1:0]    count_d, count_q;
    logic                parity_err_d, parity_err_q;
    logic                sin_ready;
    logic                accept;
    logic                shift_en;
    logic [NIBBLE_W-1:0] nibble;

    assign sin_ready = CLEAR & ((state_q != ST_FULL) | bus.D_READY);
    assign accept    = bus.SIN_VALID & sin_ready;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        parity_err_d = parity_err_q;
        shift_en     = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (count_q == CNT_W'(NIBBLE_W - 1)) begin
                        count_d = '0;
                        state_d = PARITY_EN ? ST_PARITY : ST_FULL;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (accept) begin
                    parity_err_d = bus.SIN ^ even_parity(nibble);
                    state_d      = ST_FULL;
                end
            end
            ST_FULL: begin
                // Handoff: a bit accepted on the consuming edge starts the next nibble.
                if (bus.D_READY) begin
                    parity_err_d = 1'b0;
                    state_d      = ST_COLLECT;
                    if (accept) begin
                        shift_en = 1'b1;
                        count_d  = CNT_W'(1);
                    end else begin
                        count_d  = '0;
                    end
                end
            end
            default: begin
                state_d      = ST_COLLECT;
                count_d      = '0;
                parity_err_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLEAR) begin
            state_q      <= ST_COLLECT;
            count_q      <= '0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            parity_err_q <= parity_err_d;
        end
    end

    nibble_shift_stage u_shift (
        .clk       (CLK),
        .clr_n     (CLEAR),
        .shift_en  (shift_en),
        .msb_first (MSB_FIRST),
        .din       (bus.SIN),
        .q         (nibble)
    );

    assign bus.SIN_READY  = sin_ready;
    assign bus.D_OUT      = nibble;
    assign bus.D_VALID    = (state_q == ST_FULL);
    assign bus.PARITY_ERR = parity_err_q;

endmodule
